// File: rtl/vm_pkg.sv
// Shared voting-machine types: ballot FSM states, candidate count and index type.
package vm_pkg;

  localparam int NUM_CANDIDATES = 3;

  // Zero-based candidate index (0 -> candidate 1).
  typedef logic [1:0] cand_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    CAST  = 2'd2,
    DONE  = 2'd3
  } ballot_state_t;

  function automatic logic [NUM_CANDIDATES-1:0] cand_onehot(input cand_idx_t idx);
    return NUM_CANDIDATES'(1) << idx;
  endfunction

endpackage

// File: rtl/ballot_unit_if.sv
// Panel-key inputs and vote/status outputs of the ballot unit.
interface ballot_unit_if;

  logic i_ballot_en;
  logic i_button_1;
  logic i_button_2;
  logic i_button_3;
  logic i_over;
  logic o_candidate_1;
  logic o_candidate_2;
  logic o_candidate_3;
  logic o_ready;
  logic o_vote_cast;
  logic o_error;

  modport slave (
    input  i_ballot_en, i_button_1, i_button_2, i_button_3, i_over,
    output o_candidate_1, o_candidate_2, o_candidate_3, o_ready, o_vote_cast, o_error
  );

  modport master (
    output i_ballot_en, i_button_1, i_button_2, i_button_3, i_over,
    input  o_candidate_1, o_candidate_2, o_candidate_3, o_ready, o_vote_cast, o_error
  );

endinterface

// File: rtl/key_debounce.sv
// One raw key: 2-flop synchronizer, stability-count debouncer and rising-edge detect.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic lvl,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] stable_cnt;
  logic             lvl_q;

  // p0/p1: synchronizer; the counter only advances on samples that disagree with lvl
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      stable_cnt <= '0;
      lvl        <= 1'b0;
      lvl_q      <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      lvl_q   <= lvl;
      if (sync_p1 == lvl) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        lvl        <= sync_p1;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  assign rise = lvl & ~lvl_q;

endmodule

// File: rtl/ballot_unit.sv
// Voter-side front end: debounces the panel keys and releases exactly one
// registered, one-cycle candidate strobe per armed ballot.
module ballot_unit
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  ballot_unit_if.slave   bus
);

  logic                      en_rise;
  logic                      unused_en_lvl;
  logic [NUM_CANDIDATES-1:0] cand_lvl;
  logic [NUM_CANDIDATES-1:0] cand_rise;

  ballot_state_t state_q, state_d;
  cand_idx_t     sel_q, sel_d;
  logic          err_d;

  function automatic logic [1:0] count_high(input logic [NUM_CANDIDATES-1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  function automatic cand_idx_t first_high(input logic [NUM_CANDIDATES-1:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_en (
    .clk(clk), .rst_n(rst_n), .raw(bus.i_ballot_en), .lvl(unused_en_lvl), .rise(en_rise)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_1 (
    .clk(clk), .rst_n(rst_n), .raw(bus.i_button_1), .lvl(cand_lvl[0]), .rise(cand_rise[0])
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_2 (
    .clk(clk), .rst_n(rst_n), .raw(bus.i_button_2), .lvl(cand_lvl[1]), .rise(cand_rise[1])
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_3 (
    .clk(clk), .rst_n(rst_n), .raw(bus.i_button_3), .lvl(cand_lvl[2]), .rise(cand_rise[2])
  );

  // A rise only opens the ambiguity check; the decision uses every held level,
  // so a second key already down also makes the press ambiguous.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_rise && !bus.i_over) state_d = ARMED;
      end
      ARMED: begin
        if (bus.i_over) begin
          state_d = IDLE;
        end else if (|cand_rise) begin
          if (count_high(cand_lvl) == 2'd1) begin
            state_d = CAST;
            sel_d   = first_high(cand_lvl);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CAST: state_d = DONE;
      DONE: begin
        if (cand_lvl == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      sel_q             <= '0;
      bus.o_ready       <= 1'b0;
      bus.o_vote_cast   <= 1'b0;
      bus.o_error       <= 1'b0;
      bus.o_candidate_1 <= 1'b0;
      bus.o_candidate_2 <= 1'b0;
      bus.o_candidate_3 <= 1'b0;
    end else begin
      state_q         <= state_d;
      sel_q           <= sel_d;
      bus.o_ready     <= (state_d == ARMED);
      bus.o_vote_cast <= (state_d == DONE);
      bus.o_error     <= err_d;
      {bus.o_candidate_3, bus.o_candidate_2, bus.o_candidate_1} <=
        (state_d == CAST) ? cand_onehot(sel_d) : '0;
    end
  end

endmodule
